// File: rtl/ram_toggle_port_if.sv
// ram_toggle_port_if: toggle-handshake requester port.
// master drives req/a/ds/we/d, slave returns ack/q.
interface ram_toggle_port_if #(
  parameter int AW = 15
);
  logic          req;
  logic          ack;
  logic [AW-1:0] a;
  logic [1:0]    ds;
  logic          we;
  logic [15:0]   d;
  logic [15:0]   q;

  modport master (
    output req, a, ds, we, d,
    input  ack, q
  );

  modport slave (
    input  req, a, ds, we, d,
    output ack, q
  );
endinterface

// File: rtl/ram_toggle_port.sv
// ram_toggle_port: two toggle-handshake ports sharing one sync RAM.
// Ports: clk_sys, reset (sync, active-high); port1/port2 slave
// handshakes (req/ack toggles, a, ds, we, d, q); mem_en/we/addr/
// be/din out, mem_dout in. Macro RAM_TOGGLE_PORT2_EN builds port2.
module ram_toggle_port #(
  parameter int AW     = 15,
  parameter int RD_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  ram_toggle_port_if.slave  port1,
  ram_toggle_port_if.slave  port2,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RDWAIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_a;
  logic [1:0]    r_ds;
  logic          r_we;
  logic [15:0]   r_d;
  logic [2:0]    r_cnt;
  logic          r_ack1;
  logic [15:0]   r_q1;
  logic          w_p1_pend;
  logic          w_take;
  logic          w_done_wr;
  logic          w_done_rd;

  assign w_p1_pend = port1.req != r_ack1;
  assign port1.ack = r_ack1;
  assign port1.q   = r_q1;

`ifdef RAM_TOGGLE_PORT2_EN
  logic        r_ack2;
  logic [15:0] r_q2;
  logic        r_id;
  logic        w_p2_pend;
  logic        w_sel2;

  assign w_p2_pend = port2.req != r_ack2;
  // port2 only wins when port1 has nothing pending
  assign w_sel2    = ~w_p1_pend & w_p2_pend;
  assign w_take    = w_p1_pend | w_p2_pend;
  assign port2.ack = r_ack2;
  assign port2.q   = r_q2;
`else
  logic w_unused_p2;

  assign w_take      = w_p1_pend;
  assign port2.ack   = port2.req;
  assign port2.q     = '0;
  assign w_unused_p2 = ^{port2.a, port2.ds, port2.we, port2.d};
`endif

  assign w_done_wr = (r_state == S_ISSUE) & r_we;
  assign w_done_rd = (r_state == S_RDWAIT) & (r_cnt == 3'd0);

  always_comb begin
    w_next   = r_state;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_be   = 2'b00;
    mem_din  = 16'h0000;
    unique case (r_state)
      S_IDLE: begin
        if (w_take) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_next = r_we ? S_IDLE : S_RDWAIT;
        if (!reset) begin
          mem_en   = 1'b1;
          // empty byte mask keeps write timing but never writes
          mem_we   = r_we & (r_ds != 2'b00);
          mem_addr = r_a;
          mem_be   = r_ds;
          mem_din  = r_d;
        end
      end
      S_RDWAIT: begin
        if (r_cnt == 3'd0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_ds    <= 2'b00;
      r_we    <= 1'b0;
      r_d     <= 16'h0000;
      r_cnt   <= 3'd0;
      // track req so nothing is pending at release
      r_ack1  <= port1.req;
      r_q1    <= 16'h0000;
`ifdef RAM_TOGGLE_PORT2_EN
      r_ack2  <= port2.req;
      r_q2    <= 16'h0000;
      r_id    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_take) begin
`ifdef RAM_TOGGLE_PORT2_EN
        if (w_sel2) begin
          r_a  <= port2.a;
          r_ds <= port2.ds;
          r_we <= port2.we;
          r_d  <= port2.d;
          r_id <= 1'b1;
        end else begin
          r_a  <= port1.a;
          r_ds <= port1.ds;
          r_we <= port1.we;
          r_d  <= port1.d;
          r_id <= 1'b0;
        end
`else
        r_a  <= port1.a;
        r_ds <= port1.ds;
        r_we <= port1.we;
        r_d  <= port1.d;
`endif
      end
      if (r_state == S_ISSUE)
        r_cnt <= 3'(RD_LAT - 1);
      else if (r_state == S_RDWAIT)
        r_cnt <= r_cnt - 3'd1;
`ifdef RAM_TOGGLE_PORT2_EN
      if (w_done_wr | w_done_rd) begin
        if (r_id) r_ack2 <= ~r_ack2;
        else      r_ack1 <= ~r_ack1;
      end
      if (w_done_rd) begin
        if (r_id) r_q2 <= mem_dout;
        else      r_q1 <= mem_dout;
      end
`else
      if (w_done_wr | w_done_rd)
        r_ack1 <= ~r_ack1;
      if (w_done_rd)
        r_q1 <= mem_dout;
`endif
    end
  end

endmodule

// File: tb/tb_ram_toggle_port.sv
// tb_ram_toggle_port: randomized self-checking bench with a
// behavioural memory/latency model for ram_toggle_port.
module tb_ram_toggle_port;
  localparam int AW     = 15;
  localparam int RD_LAT = 2;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_be;
  logic [15:0]   mem_din;
  logic [15:0]   mem_dout;

  always #5 clk_sys = ~clk_sys;

  ram_toggle_port_if #(.AW(AW)) p1 ();
  ram_toggle_port_if #(.AW(AW)) p2 ();

  ram_toggle_port #(
    .AW(AW),
    .RD_LAT(RD_LAT)
  ) u_dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .port1   (p1),
    .port2   (p2),
    .mem_en  (mem_en),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_be  (mem_be),
    .mem_din (mem_din),
    .mem_dout(mem_dout)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] ram     [0:(1<<AW)-1];
  logic [15:0] exp_mem [0:(1<<AW)-1];

  int            en_cnt = 0;
  int            we_cnt = 0;
  logic [AW-1:0] mon_addr;
  logic [1:0]    mon_be;
  logic [15:0]   mon_din;

  // external synchronous RAM
  always @(posedge clk_sys) begin
    if (mem_en) begin
      if (mem_we) begin
        if (mem_be[1]) ram[mem_addr][15:8] <= mem_din[15:8];
        if (mem_be[0]) ram[mem_addr][7:0]  <= mem_din[7:0];
      end else begin
        mem_dout <= ram[mem_addr];
      end
    end
  end

  always @(negedge clk_sys) begin
    if (mem_en) begin
      en_cnt   <= en_cnt + 1;
      mon_addr <= mem_addr;
      mon_be   <= mem_be;
      mon_din  <= mem_din;
      if (mem_we) we_cnt <= we_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] merge(
    input logic [15:0] o,
    input logic [15:0] d,
    input logic [1:0]  ds
  );
    logic [15:0] r;
    r = o;
    if (ds[1]) r[15:8] = d[15:8];
    if (ds[0]) r[7:0]  = d[7:0];
    return r;
  endfunction

  task automatic drive(
    input int            port,
    input logic          we,
    input logic [AW-1:0] a,
    input logic [1:0]    ds,
    input logic [15:0]   d
  );
    if (port == 1) begin
      p1.we = we; p1.a = a; p1.ds = ds; p1.d = d;
    end else begin
      p2.we = we; p2.a = a; p2.ds = ds; p2.d = d;
    end
  endtask

  task automatic toggle(input int port);
    if (port == 1) p1.req = ~p1.req;
    else           p2.req = ~p2.req;
  endtask

  function automatic logic get_ack(input int port);
    return (port == 1) ? p1.ack : p2.ack;
  endfunction

  function automatic logic [15:0] get_q(input int port);
    return (port == 1) ? p1.q : p2.q;
  endfunction

  task automatic run_xact(
    input int            port,
    input logic          we,
    input logic [AW-1:0] a,
    input logic [1:0]    ds,
    input logic [15:0]   d,
    input bit            scramble,
    input string         name
  );
    logic        a0;
    logic        oack;
    logic [15:0] oq;
    logic [15:0] exp_q;
    int          lat;
    int          exp_lat;
    int          exp_w;
    int          en0;
    int          we0;
    exp_lat = we ? 1 : 1 + RD_LAT;
    exp_w   = (we && ds != 2'b00) ? 1 : 0;
    exp_q   = 16'h0000;
    if (we) exp_mem[a] = merge(exp_mem[a], d, ds);
    else    exp_q = exp_mem[a];
    oq   = get_q(3 - port);
    oack = get_ack(3 - port);
    en0  = en_cnt;
    we0  = we_cnt;
    a0   = get_ack(port);
    drive(port, we, a, ds, d);
    toggle(port);
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_sys); #1;
      if (get_ack(port) !== a0) begin
        lat = k;
        break;
      end
      if (k == 0 && scramble)
        drive(port, 1'($urandom), AW'($urandom),
              2'($urandom), 16'($urandom));
    end
    n_chk++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s ack latency: got %0d want %0d",
               name, lat, exp_lat);
    end
    n_chk++;
    if (en_cnt - en0 != 1) begin
      n_fail++;
      $display("FAIL %s mem_en cycles: got %0d want 1",
               name, en_cnt - en0);
    end
    n_chk++;
    if (we_cnt - we0 != exp_w) begin
      n_fail++;
      $display("FAIL %s mem_we cycles: got %0d want %0d",
               name, we_cnt - we0, exp_w);
    end
    n_chk++;
    if (mon_addr !== a) begin
      n_fail++;
      $display("FAIL %s mem_addr: got %h want %h",
               name, mon_addr, a);
    end
    if (exp_w == 1) begin
      n_chk++;
      if (mon_be !== ds || mon_din !== d) begin
        n_fail++;
        $display("FAIL %s be/din: got %b/%h want %b/%h",
                 name, mon_be, mon_din, ds, d);
      end
    end
    if (!we) begin
      n_chk++;
      if (get_q(port) !== exp_q) begin
        n_fail++;
        $display("FAIL %s q: got %h want %h",
                 name, get_q(port), exp_q);
      end
    end
    n_chk++;
    if (get_q(3 - port) !== oq || get_ack(3 - port) !== oack) begin
      n_fail++;
      $display("FAIL %s other port: got q=%h ack=%b want q=%h ack=%b",
               name, get_q(3 - port), get_ack(3 - port), oq, oack);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    p1.req = 1'b0;
    p2.req = 1'b0;
    drive(1, 1'b0, '0, 2'b00, 16'h0);
    drive(2, 1'b0, '0, 2'b00, 16'h0);
    repeat (3) @(posedge clk_sys);
    #1;
    toggle(1);
    toggle(2);
    @(posedge clk_sys); #1;
    n_chk++;
    if (p1.ack !== p1.req || p2.ack !== p2.req) begin
      n_fail++;
      $display("FAIL reset_ack: got %b%b want %b%b",
               p1.ack, p2.ack, p1.req, p2.req);
    end
    n_chk++;
    if (p1.q !== 16'h0 || p2.q !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_q: got %h/%h want 0000/0000", p1.q, p2.q);
    end
    n_chk++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mem: got en=%b we=%b want 0/0",
               mem_en, mem_we);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_preload;
    run_xact(1, 1'b0, AW'(16'h0010), 2'b00, 16'h0, 1'b0, "read_preload");
    n_chk++;
    if (p1.q !== 16'h1234) begin
      n_fail++;
      $display("FAIL read_preload_value: got %h want 1234", p1.q);
    end
  endtask

  task automatic test_partial_write;
    run_xact(1, 1'b1, AW'(16'h0020), 2'b10, 16'hABCD, 1'b0, "wr_hi");
    run_xact(1, 1'b0, AW'(16'h0020), 2'b00, 16'h0, 1'b0, "rd_hi");
    n_chk++;
    if (p1.q !== 16'hAB66) begin
      n_fail++;
      $display("FAIL wr_hi_value: got %h want ab66", p1.q);
    end
  endtask

  task automatic test_ds_zero;
    run_xact(1, 1'b1, AW'(16'h0030), 2'b00, 16'hFFFF, 1'b0, "wr_ds0");
    run_xact(1, 1'b0, AW'(16'h0030), 2'b11, 16'h0, 1'b0, "rd_ds0");
  endtask

  task automatic test_random;
    int port;
    for (int i = 0; i < 40; i++) begin
      port = 1;
`ifdef RAM_TOGGLE_PORT2_EN
      port = int'($urandom_range(1, 2));
`endif
      run_xact(port, 1'($urandom), AW'($urandom_range(0, 63)),
               2'($urandom), 16'($urandom), 1'b1, "random");
    end
  endtask

`ifdef RAM_TOGGLE_PORT2_EN
  task automatic test_both_ports;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        k1;
    logic        k2;
    int          l1;
    int          l2;
    int          f1;
    int          f2;
    int          en0;
    e1 = exp_mem[16'h0010];
    e2 = exp_mem[16'h0021];
    drive(1, 1'b0, AW'(16'h0010), 2'b00, 16'h0);
    drive(2, 1'b0, AW'(16'h0021), 2'b00, 16'h0);
    k1 = p1.ack; k2 = p2.ack;
    l1 = -1; l2 = -1; f1 = 0; f2 = 0;
    en0 = en_cnt;
    toggle(1);
    toggle(2);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_sys); #1;
      if (p1.ack !== k1) begin
        f1++; k1 = p1.ack;
        if (l1 < 0) l1 = k;
      end
      if (p2.ack !== k2) begin
        f2++; k2 = p2.ack;
        if (l2 < 0) l2 = k;
      end
    end
    n_chk++;
    if (l1 != 1 + RD_LAT || l2 != 2 * RD_LAT + 3) begin
      n_fail++;
      $display("FAIL both_order: got %0d/%0d want %0d/%0d",
               l1, l2, 1 + RD_LAT, 2 * RD_LAT + 3);
    end
    n_chk++;
    if (f1 != 1 || f2 != 1 || en_cnt - en0 != 2) begin
      n_fail++;
      $display("FAIL both_count: got flips %0d/%0d en %0d want 1/1 en 2",
               f1, f2, en_cnt - en0);
    end
    n_chk++;
    if (p1.q !== e1 || p2.q !== e2) begin
      n_fail++;
      $display("FAIL both_q: got %h/%h want %h/%h", p1.q, p2.q, e1, e2);
    end
  endtask
`else
  task automatic test_port2_off;
    int en0;
    en0 = en_cnt;
    drive(2, 1'b0, AW'(16'h0010), 2'b11, 16'h0);
    toggle(2);
    #1;
    n_chk++;
    if (p2.ack !== p2.req) begin
      n_fail++;
      $display("FAIL p2_mirror: got %b want %b", p2.ack, p2.req);
    end
    repeat (5) @(posedge clk_sys);
    #1;
    n_chk++;
    if (en_cnt != en0 || p2.q !== 16'h0 || p2.ack !== p2.req) begin
      n_fail++;
      $display("FAIL p2_off: got en %0d q %h ack %b want en 0 q 0000 ack %b",
               en_cnt - en0, p2.q, p2.ack, p2.req);
    end
  endtask
`endif

  task automatic test_reset_mid;
    int   en0;
    logic a1;
    bit   chg;
    en0 = en_cnt;
    drive(1, 1'b0, AW'(16'h0010), 2'b00, 16'h0);
    toggle(1);
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    n_chk++;
    if (p1.q !== 16'h0 || p1.ack !== p1.req) begin
      n_fail++;
      $display("FAIL rst_mid: got q %h ack %b want q 0000 ack %b",
               p1.q, p1.ack, p1.req);
    end
    a1  = p1.ack;
    chg = 1'b0;
    repeat (6) begin
      @(posedge clk_sys); #1;
      if (p1.ack !== a1 || p1.q !== 16'h0) chg = 1'b1;
    end
    n_chk++;
    if (chg || en_cnt - en0 != 1) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got chg %0d en %0d want 0 and 1",
               chg, en_cnt - en0);
    end
    run_xact(1, 1'b0, AW'(16'h0010), 2'b00, 16'h0, 1'b0, "rst_after");
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 64; i++) begin
      v = 16'($urandom);
      ram[i]     = v;
      exp_mem[i] = v;
    end
    ram[16'h0010]     = 16'h1234;
    exp_mem[16'h0010] = 16'h1234;
    ram[16'h0020]     = 16'h5566;
    exp_mem[16'h0020] = 16'h5566;
    test_reset;
    test_read_preload;
    test_partial_write;
    test_ds_zero;
    test_random;
`ifdef RAM_TOGGLE_PORT2_EN
    test_both_ports;
`else
    test_port2_off;
`endif
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_toggle_port.md
RAM_TOGGLE_PORT -- requirements
Module: ram_toggle_port

Interface
REQ-001 Parameter AW, default 15, memory word-address width.
REQ-002 Parameter RD_LAT, default 2, memory read latency in clk_sys edges after the issuing edge (legal 1..4).
REQ-003 clk_sys  in  1  single clock; every register is clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 portN_req  in  1  request toggle for port N (N=1,2); a request is pending when portN_req != portN_ack.
REQ-006 portN_ack  out  1  acknowledge toggle; it flips once per completed request.
REQ-007 portN_a  in  AW  word address.
REQ-008 portN_ds  in  2  byte enables {hi,lo}, used for writes only.
REQ-009 portN_we  in  1  1=write, 0=read.
REQ-010 portN_d  in  16  write data.
REQ-011 portN_q  out  16  read data, held until the next read completes on the same port.
REQ-012 mem_en, mem_we  out  1 each  memory strobe and write qualifier, valid for one cycle.
REQ-013 mem_addr  out  AW; mem_be  out  2; mem_din  out  16; mem_dout  in  16.

Function
REQ-014 FSM states: IDLE, ISSUE, RDWAIT; the current state is held in a register.
REQ-015 In IDLE at an edge with any port pending: latch that port's a/ds/we/d and its port id, and go to ISSUE.
REQ-016 Arbitration is fixed priority, port1 over port2; port2 is served only on an edge where port1 is not pending.
REQ-017 In ISSUE (exactly one cycle):
  - mem_en=1 and mem_addr=latched a.
  - mem_we=latched we AND (ds!=00).
  - mem_be=latched ds; mem_din=latched d.
  - In every other state all mem_* outputs are 0.
REQ-018 Write: at the edge ending ISSUE, toggle the served port's ack and go to IDLE; write ack follows the request-sampling edge by 1 edge.
REQ-019 Write with ds=00: no memory write occurs, and ack still toggles with write timing.
REQ-020 Read: after ISSUE, go to RDWAIT and count RD_LAT edges.
REQ-021 Read completion: at the edge where the count expires, capture mem_dout into the served port's q, toggle its ack, and go to IDLE; q and ack change on the same edge, 1+RD_LAT edges after the sampling edge.
REQ-022 Reads ignore ds and return the full 16-bit word.
REQ-023 A completing state always returns to IDLE, so one transaction occupies at least 2 cycles and pending requests are re-sampled on the next edge.
REQ-024 Requests that arrive while busy remain pending and are served in priority order; no request is lost.
REQ-025 A requester shall not toggle req again before its ack returns; if it does, pending status is re-evaluated only in IDLE, and req==ack is treated as no request.
REQ-026 Changing portN_a/ds/we/d after the sampling edge does not affect the transaction in flight.
REQ-027 The other port's q and ack never change during a transaction.

Reset
REQ-028 While reset=1:
  - state=IDLE; mem_* outputs = 0; portN_q=0.
  - portN_ack <= portN_req on every edge, so no spurious pending request exists at release.
REQ-029 Reset asserted mid-transaction abandons it: no ack toggle, and no q update.
REQ-030 The first request can be sampled on the first edge after reset deasserts.

Configuration
REQ-031 Macro RAM_TOGGLE_PORT2_EN defined: both ports are present and arbitration follows REQ-016.
REQ-032 Macro RAM_TOGGLE_PORT2_EN undefined:
  - port2 inputs are ignored; port2_ack = port2_req and port2_q = 0.
  - no arbitration logic is built, and port1 timing is identical to the defined case.

Verification
REQ-033 RD_LAT=2, memory preloaded with 0x1234 at 0x0010; toggle port1_req (we=0, a=0x0010) -> mem_en for 1 cycle; port1_q=0x1234 and port1_ack flips 3 edges after sampling.
REQ-034 port1 write a=0x0020, d=0xABCD, ds=10 -> mem_we=1, be=10 for one cycle; ack flips 1 edge after sampling; a read of 0x0020 returns 0xAB in the high byte and the low byte unchanged.
REQ-035 Toggle both ports on the same edge (two reads) -> port1 is served first; port2 ISSUE starts 1 edge after port1 completes; both acks flip exactly once.
REQ-036 Write with ds=00 -> mem_we stays 0 throughout; ack still flips after 1 edge.
REQ-037 Assert reset for 1 cycle during RDWAIT -> no ack flip and q stays 0; after release, a new request completes normally.
REQ-038 Build without RAM_TOGGLE_PORT2_EN and toggle port2_req -> port2_ack mirrors it; mem_en stays 0.
